// File: rtl/icache_dm.sv
// ---------------------------------------------------------------------------
// icache_dm -- parametrised direct-mapped instruction cache
//
// Sits between the core's instruction fetch and instruction memory. A hit
// returns the instruction combinationally in the same cycle. A miss raises
// busy and refills the whole line with a pipelined burst of word reads
// against a fixed-latency memory. A flush pulse invalidates every line and
// aborts any fill in progress.
//
// Parameters
//   ADDR_W          instruction word-address width
//   DATA_W          instruction width
//   LINES           number of lines (power of 2, >= 2)
//   WORDS_PER_LINE  words per line (power of 2, >= 1)
//   MEM_LAT         memory read latency in enabled cycles (>= 1)
//
// Ports
//   clk          in   clock
//   sync_rst     in   synchronous active-high reset
//   clk_en       in   global enable; low freezes all state
//   req          in   fetch request from the core
//   flush        in   invalidate all lines (single-cycle pulse)
//   address_in   in   fetch word address
//   from_mem     in   instruction memory read data
//   inst_out     out  instruction for address_in (valid when req & ~busy)
//   address_out  out  memory read address (registered)
//   busy         out  stall to the core (combinational)
//   mreq         out  memory read request (registered)
// ---------------------------------------------------------------------------
module icache_dm #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 16,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LAT        = 1
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic              clk_en,
    input  logic              req,
    input  logic              flush,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] from_mem,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] address_out,
    output logic              busy,
    output logic              mreq
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    // index and offset together form the flat word slot in the data array
    localparam int SLOT_W = OFF_W + IDX_W;
    localparam int SLOTS  = LINES * WORDS_PER_LINE;
    localparam int CNT_W  = $clog2(WORDS_PER_LINE + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    // control state
    logic [0:0]        state_q,       state_d;
    logic [LINES-1:0]  valid_q,       valid_d;
    logic              mreq_q,        mreq_d;
    logic [ADDR_W-1:0] address_out_q, address_out_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [IDX_W-1:0]  fill_idx_q,    fill_idx_d;
    logic [TAG_W-1:0]  fill_tag_q,    fill_tag_d;

    // in-flight tracker: one stage per cycle of memory latency
    logic [MEM_LAT-1:0] pipe_v_q,    pipe_v_d;
    logic [MEM_LAT-1:0] pipe_last_q, pipe_last_d;
    logic [SLOT_W-1:0]  pipe_slot_q [MEM_LAT];
    logic [SLOT_W-1:0]  pipe_slot_d [MEM_LAT];

    // storage (contents are qualified by valid_q, so not reset)
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [SLOTS];

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [SLOT_W-1:0] slot_s;
    logic [ADDR_W-1:0] base_s;
    logic              hit_s;
    logic              capture_s;
    logic              last_s;

    assign idx_s  = address_in[OFF_W +: IDX_W];
    assign tag_s  = address_in[ADDR_W-1 -: TAG_W];
    assign slot_s = address_in[SLOT_W-1:0];
    assign base_s = address_in & ~ADDR_W'(WORDS_PER_LINE - 1);
    assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

    // The oldest tracker stage holds the word whose data is on from_mem now.
    // A flush in the same cycle discards it.
    assign capture_s = (state_q == S_FILL) && !flush && pipe_v_q[MEM_LAT-1];
    assign last_s    = capture_s && pipe_last_q[MEM_LAT-1];

    assign inst_out    = data_q[slot_s];
    assign busy        = (state_q != S_IDLE) || (req && !hit_s);
    assign mreq        = mreq_q;
    assign address_out = address_out_q;

    // Next-state logic for the fill controller and in-flight tracker
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        mreq_d        = mreq_q;
        address_out_d = address_out_q;
        cnt_d         = cnt_q;
        fill_idx_d    = fill_idx_q;
        fill_tag_d    = fill_tag_q;

        // a word is issued in every cycle mreq is high; it enters the tracker
        pipe_v_d[0]    = mreq_q;
        pipe_last_d[0] = mreq_q && (cnt_q == CNT_W'(WORDS_PER_LINE));
        pipe_slot_d[0] = address_out_q[SLOT_W-1:0];
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v_d[i]    = pipe_v_q[i-1];
            pipe_last_d[i] = pipe_last_q[i-1];
            pipe_slot_d[i] = pipe_slot_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    // flush beats a simultaneous miss; the miss retries next cycle
                    valid_d = '0;
                end else if (req && !hit_s) begin
                    state_d             = S_FILL;
                    valid_d[idx_s]      = 1'b0;
                    fill_idx_d          = idx_s;
                    fill_tag_d          = tag_s;
                    mreq_d              = 1'b1;
                    address_out_d       = base_s;
                    cnt_d               = CNT_W'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (flush) begin
                    valid_d  = '0;
                    mreq_d   = 1'b0;
                    pipe_v_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    // cnt_q counts words already presented on address_out
                    if (mreq_q) begin
                        if (cnt_q == CNT_W'(WORDS_PER_LINE)) begin
                            mreq_d = 1'b0;
                        end else begin
                            address_out_d = address_out_q + ADDR_W'(1);
                            cnt_d         = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        mreq_d = 1'b0;
                    end
                    if (last_s) begin
                        valid_d[fill_idx_q] = 1'b1;
                        pipe_v_d            = '0;
                        state_d             = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                mreq_d   = 1'b0;
                pipe_v_d = '0;
            end
        endcase
    end

    // Control registers: synchronous reset, frozen while clk_en is low
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q       <= S_IDLE;
            valid_q       <= '0;
            mreq_q        <= 1'b0;
            address_out_q <= '0;
            cnt_q         <= '0;
            fill_idx_q    <= '0;
            fill_tag_q    <= '0;
            pipe_v_q      <= '0;
            pipe_last_q   <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_slot_q[i] <= '0;
            end
        end else if (clk_en) begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            mreq_q        <= mreq_d;
            address_out_q <= address_out_d;
            cnt_q         <= cnt_d;
            fill_idx_q    <= fill_idx_d;
            fill_tag_q    <= fill_tag_d;
            pipe_v_q      <= pipe_v_d;
            pipe_last_q   <= pipe_last_d;
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_slot_q[i] <= pipe_slot_d[i];
            end
        end
    end

    // Line storage: capture returning words, commit the tag with the last word
    always_ff @(posedge clk) begin
        if (!sync_rst && clk_en) begin
            if (capture_s) begin
                data_q[pipe_slot_q[MEM_LAT-1]] <= from_mem;
            end
            if (last_s) begin
                tag_q[fill_idx_q] <= fill_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// ---------------------------------------------------------------------------
// tb_icache_dm -- self-checking bench for icache_dm
//
// Two configurations run side by side: the default one and
// LINES=4 / WORDS_PER_LINE=8 / MEM_LAT=3. Each has a fixed-latency memory
// returning address ^ salt and a behavioural model that tracks a fill as
// "enabled cycles since the miss", from which busy, mreq, address_out and
// hit data are predicted.
// ---------------------------------------------------------------------------
module tb_icache_dm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Single comparison point: counts and reports mismatches
    task automatic check_val(input string tag, input int cfg_id,
                             input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cfg%0d): got %0h, expected %0h", tag, cfg_id, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int AW    = 10;
        localparam int DW    = 16;
        localparam int NL    = (g == 0) ? 16 : 4;
        localparam int NW    = (g == 0) ? 4  : 8;
        localparam int LAT   = (g == 0) ? 1  : 3;
        localparam int SLOTS = NL * NW;

        logic          sync_rst, clk_en, req, flush;
        logic [AW-1:0] address_in, address_out;
        logic [DW-1:0] from_mem, inst_out;
        logic          busy, mreq;
        logic [DW-1:0] salt = 16'hA000;
        logic [AW-1:0] mpipe [LAT];
        bit            done_g = 1'b0;

        icache_dm #(
            .ADDR_W(AW), .DATA_W(DW), .LINES(NL),
            .WORDS_PER_LINE(NW), .MEM_LAT(LAT)
        ) dut (
            .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .req(req),
            .flush(flush), .address_in(address_in), .from_mem(from_mem),
            .inst_out(inst_out), .address_out(address_out), .busy(busy),
            .mreq(mreq)
        );

        // Memory: data for an address appears LAT enabled cycles later
        always @(posedge clk) begin
            if (clk_en) begin
                mpipe[0] <= address_out;
                for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
            end
        end
        assign from_mem = DW'(mpipe[LAT-1]) ^ salt;

        // Reference model state
        bit            m_valid [NL];
        int            m_tag   [NL];
        logic [DW-1:0] m_word  [SLOTS];
        bit            m_fill;
        int            m_p;
        int            m_base;
        int            m_aout;

        task automatic m_reset();
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_fill = 1'b0;
            m_p    = 0;
            m_aout = 0;
        endtask

        function automatic bit m_hit(input int a);
            int line;
            line = (a / NW) % NL;
            return m_valid[line] && (m_tag[line] == a / SLOTS);
        endfunction

        // One clock cycle: drive inputs, check outputs, advance the model
        task automatic step(input bit r, input int a, input bit f,
                            input bit en, input bit rst, output bit b_obs);
            bit h, e_busy, e_mreq;
            int e_aout, k, line;
            sync_rst   = rst;
            clk_en     = en;
            req        = r;
            flush      = f;
            address_in = AW'(a);
            #1;
            h      = m_hit(a);
            k      = (m_p < NW) ? m_p : NW;
            e_busy = m_fill || (r && !h);
            e_mreq = m_fill && (m_p <= NW);
            e_aout = m_fill ? (m_base + k - 1) : m_aout;
            check_val("busy", g, 32'(busy), 32'(e_busy));
            check_val("mreq", g, 32'(mreq), 32'(e_mreq));
            check_val("address_out", g, 32'(address_out), 32'(e_aout));
            if (r && !e_busy) check_val("inst_out", g, 32'(inst_out), 32'(m_word[a % SLOTS]));
            b_obs = busy;
            if (rst) begin
                m_reset();
            end else if (en) begin
                if (m_fill) begin
                    m_aout = e_aout;
                    if (f) begin
                        m_fill = 1'b0;
                        foreach (m_valid[i]) m_valid[i] = 1'b0;
                    end else if (m_p == NW + LAT) begin
                        line          = (m_base / NW) % NL;
                        m_valid[line] = 1'b1;
                        m_tag[line]   = m_base / SLOTS;
                        for (int j = 0; j < NW; j++)
                            m_word[(m_base % SLOTS) + j] = DW'(m_base + j) ^ salt;
                        m_fill = 1'b0;
                    end else begin
                        m_p++;
                    end
                end else if (f) begin
                    foreach (m_valid[i]) m_valid[i] = 1'b0;
                end else if (r && !h) begin
                    m_fill = 1'b1;
                    m_p    = 1;
                    m_base = a - (a % NW);
                    m_valid[(a / NW) % NL] = 1'b0;
                end
            end
            @(negedge clk);
        endtask

        // Present a fetch until it is served; counts enabled busy cycles.
        // An optional 3-cycle clk_en hole starts at cycle hole_at.
        task automatic miss_lat(input int a, input int hole_at, output int n);
            bit b, en;
            n = 0;
            for (int c = 0; c < 60; c++) begin
                en = !(hole_at >= 0 && c >= hole_at && c < hole_at + 3);
                step(1'b1, a, 1'b0, en, 1'b0, b);
                if (!b) break;
                if (en) n++;
            end
        endtask

        initial begin
            bit b;
            int n;
            int a0;
            a0 = 5;
            sync_rst = 1'b1; clk_en = 1'b1; req = 1'b0; flush = 1'b0;
            address_in = '0;
            @(posedge clk);
            m_reset();
            @(negedge clk);
            step(1'b0, 0, 1'b0, 1'b1, 1'b1, b);
            // reset state
            check_val("rst_busy", g, 32'(busy), 32'd0);
            check_val("rst_mreq", g, 32'(mreq), 32'd0);

            // cold miss, then first hit
            miss_lat(a0, -1, n);
            check_val("cold_miss_lat", g, 32'(n), 32'(NW + LAT + 1));
            #1;
            check_val("first_hit", g, 32'(inst_out), 32'(DW'(a0) ^ salt));
            // neighbouring words hit without touching memory
            step(1'b1, a0 + 1, 1'b0, 1'b1, 1'b0, b);
            step(1'b1, a0 + 2, 1'b0, 1'b1, 1'b0, b);
            // conflict: same index, new tag, then the original misses again
            miss_lat(a0 + SLOTS, -1, n);
            check_val("conflict_lat", g, 32'(n), 32'(NW + LAT + 1));
            miss_lat(a0, -1, n);
            check_val("remiss_lat", g, 32'(n), 32'(NW + LAT + 1));

            // flush in fill cycle 3 with new memory contents; refill is clean
            salt = 16'h5C00;
            step(1'b0, 0, 1'b1, 1'b1, 1'b0, b);
            step(1'b1, a0, 1'b0, 1'b1, 1'b0, b);
            step(1'b1, a0, 1'b0, 1'b1, 1'b0, b);
            step(1'b1, a0, 1'b0, 1'b1, 1'b0, b);
            step(1'b1, a0, 1'b1, 1'b1, 1'b0, b);
            #1;
            check_val("abort_mreq", g, 32'(mreq), 32'd0);
            miss_lat(a0, -1, n);
            check_val("refill_lat", g, 32'(n), 32'(NW + LAT + 1));
            for (int j = 0; j < NW; j++) step(1'b1, a0 - (a0 % NW) + j, 1'b0, 1'b1, 1'b0, b);

            // clk_en hole mid-fill does not change the enabled busy count
            miss_lat(a0 + 3 * NW, 2, n);
            check_val("stall_lat", g, 32'(n), 32'(NW + LAT + 1));

            // sync_rst mid-fill leaves every line invalid
            step(1'b1, a0 + 5 * NW, 1'b0, 1'b1, 1'b0, b);
            step(1'b1, a0 + 5 * NW, 1'b0, 1'b1, 1'b0, b);
            step(1'b1, a0 + 5 * NW, 1'b0, 1'b1, 1'b1, b);
            #1;
            check_val("post_rst_mreq", g, 32'(mreq), 32'd0);
            miss_lat(a0, -1, n);
            check_val("post_rst_lat", g, 32'(n), 32'(NW + LAT + 1));

            // randomized traffic over a few tags per index
            for (int c = 0; c < 500; c++) begin
                bit r, f, en, rst;
                int a;
                r   = ($urandom_range(0, 9) != 0);
                a   = ($urandom_range(0, 3) * SLOTS + $urandom_range(0, SLOTS - 1)) % 1024;
                f   = ($urandom_range(0, 39) == 0);
                en  = ($urandom_range(0, 7) != 0);
                rst = en && ($urandom_range(0, 199) == 0);
                step(r, a, f, en, rst, b);
            end
            done_g = 1'b1;
        end
    end

    // Summary once both configurations finish, with a cycle budget
    initial begin
        int cyc;
        cyc = 0;
        while (!(cfg[0].done_g && cfg[1].done_g) && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check_val("completion", 0, 32'(cfg[0].done_g && cfg[1].done_g), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
